mdu_control: RTL and testbench

- Sequencer for an iterative multiply/divide unit beside the EX-stage ALU.
- Accepts R-type MULT/MULTU/DIV/DIVU/MTHI/MTLO funct codes from EX and runs a shift-add multiply or restoring divide, one bit per cycle.
- Owns the HI/LO registers.
- Drives a busy/stall handshake so the pipeline holds dependent MFHI/MFLO and further mult/div issue until the result is ready.

---
 rtl/mdu_control_if.sv | 28 ++
 rtl/mdu_control.sv | 174 +++++++++++++++++
 tb/tb_mdu_control.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_control_if.sv
// EX-stage <-> multiply/divide sequencer bus: operation request in, HI/LO state and status out.
// Handshake: EX may assert i_start with i_funct/i_op_a/i_op_b at any edge; the op is taken
// only on an edge where o_busy is low, otherwise the request is dropped (EX stalls on o_busy).
interface mdu_control_if #(
    parameter int DATA_BUS_WIDTH      = 32,
    parameter int ALU_FUNCT_BUS_WIDTH = 6
);
    logic                           i_start;
    logic [ALU_FUNCT_BUS_WIDTH-1:0] i_funct;
    logic [DATA_BUS_WIDTH-1:0]      i_op_a;
    logic [DATA_BUS_WIDTH-1:0]      i_op_b;
    logic                           o_busy;
    logic                           o_done;
    logic                           o_div_by_zero;
    logic [DATA_BUS_WIDTH-1:0]      o_hi;
    logic [DATA_BUS_WIDTH-1:0]      o_lo;
    logic [1:0]                     o_dbg_state;

    modport master (
        output i_start, i_funct, i_op_a, i_op_b,
        input  o_busy, o_done, o_div_by_zero, o_hi, o_lo, o_dbg_state
    );

    modport slave (
        input  i_start, i_funct, i_op_a, i_op_b,
        output o_busy, o_done, o_div_by_zero, o_hi, o_lo, o_dbg_state
    );
endinterface

// File: rtl/mdu_control.sv
// Iterative multiply/divide sequencer owning HI/LO: shift-add multiply and restoring divide,
// one bit per clock, with sign handling done on magnitudes before and after the loop.
module mdu_control #(
    parameter int DATA_BUS_WIDTH      = 32,
    parameter int ALU_FUNCT_BUS_WIDTH = 6
) (
    input logic          i_clk,
    input logic          i_reset,
    mdu_control_if.slave bus
);
    localparam int W  = DATA_BUS_WIDTH;
    localparam int CW = $clog2(W);

    localparam logic [ALU_FUNCT_BUS_WIDTH-1:0] FN_MTHI  = ALU_FUNCT_BUS_WIDTH'('h11);
    localparam logic [ALU_FUNCT_BUS_WIDTH-1:0] FN_MTLO  = ALU_FUNCT_BUS_WIDTH'('h13);
    localparam logic [ALU_FUNCT_BUS_WIDTH-1:0] FN_MULT  = ALU_FUNCT_BUS_WIDTH'('h18);
    localparam logic [ALU_FUNCT_BUS_WIDTH-1:0] FN_MULTU = ALU_FUNCT_BUS_WIDTH'('h19);
    localparam logic [ALU_FUNCT_BUS_WIDTH-1:0] FN_DIV   = ALU_FUNCT_BUS_WIDTH'('h1A);
    localparam logic [ALU_FUNCT_BUS_WIDTH-1:0] FN_DIVU  = ALU_FUNCT_BUS_WIDTH'('h1B);

    typedef enum logic [1:0] {IDLE, RUN_MUL, RUN_DIV, FIX} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   opb_q, opb_d;         // multiplicand or divisor magnitude
    logic [W-1:0]   work_hi_q, work_hi_d; // product upper half / partial remainder
    logic [W-1:0]   work_lo_q, work_lo_d; // multiplier shifting out / quotient shifting in
    logic           is_div_q, is_div_d;
    logic           neg_lo_q, neg_lo_d;
    logic           neg_hi_q, neg_hi_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           done_q, done_d;
    logic           dbz_q, dbz_d;

    logic           signed_op;
    logic           a_neg, b_neg;
    logic [W-1:0]   a_mag, b_mag;
    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic [2*W-1:0] product;

    always_comb begin
        signed_op = (bus.i_funct == FN_MULT) || (bus.i_funct == FN_DIV);
        a_neg     = signed_op && bus.i_op_a[W-1];
        b_neg     = signed_op && bus.i_op_b[W-1];
        a_mag     = a_neg ? -bus.i_op_a : bus.i_op_a;
        b_mag     = b_neg ? -bus.i_op_b : bus.i_op_b;

        mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opb_q} : '0);
        // Partial remainder stays below the divisor, so W+1 bits hold the shifted value.
        div_shift = {work_hi_q, work_lo_q[W-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        product   = {work_hi_q, work_lo_q};
        if (neg_lo_q) product = -product;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opb_d     = opb_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        is_div_d  = is_div_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    if (bus.i_funct == FN_MTHI) begin
                        hi_d = bus.i_op_a;
                    end else if (bus.i_funct == FN_MTLO) begin
                        lo_d = bus.i_op_a;
                    end else if (bus.i_funct == FN_MULT || bus.i_funct == FN_MULTU) begin
                        opb_d     = a_mag;
                        work_lo_d = b_mag;
                        work_hi_d = '0;
                        is_div_d  = 1'b0;
                        neg_lo_d  = a_neg ^ b_neg;
                        neg_hi_d  = 1'b0;
                        cnt_d     = CW'(W - 1);
                        state_d   = RUN_MUL;
                    end else if (bus.i_funct == FN_DIV || bus.i_funct == FN_DIVU) begin
                        if (bus.i_op_b == '0) begin
                            done_d = 1'b1;
                            dbz_d  = 1'b1;
                        end else begin
                            opb_d     = b_mag;
                            work_lo_d = a_mag;
                            work_hi_d = '0;
                            is_div_d  = 1'b1;
                            neg_lo_d  = a_neg ^ b_neg;
                            neg_hi_d  = a_neg;
                            cnt_d     = CW'(W - 1);
                            state_d   = RUN_DIV;
                        end
                    end
                end
            end
            RUN_MUL: begin
                work_hi_d = mul_sum[W:1];
                work_lo_d = {mul_sum[0], work_lo_q[W-1:1]};
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = FIX;
            end
            RUN_DIV: begin
                if (!div_diff[W]) begin
                    work_hi_d = div_diff[W-1:0];
                    work_lo_d = {work_lo_q[W-2:0], 1'b1};
                end else begin
                    work_hi_d = div_shift[W-1:0];
                    work_lo_d = {work_lo_q[W-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    lo_d = neg_lo_q ? -work_lo_q : work_lo_q;
                    hi_d = neg_hi_q ? -work_hi_q : work_hi_q;
                end else begin
                    {hi_d, lo_d} = product;
                end
                cnt_d   = '0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            opb_q     <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            is_div_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opb_q     <= opb_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            is_div_q  <= is_div_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.o_busy        = (state_q != IDLE);
    assign bus.o_done        = done_q;
    assign bus.o_div_by_zero = dbz_q;
    assign bus.o_hi          = hi_q;
    assign bus.o_lo          = lo_q;
    assign bus.o_dbg_state   = state_q;
endmodule

// File: tb/tb_mdu_control.sv
// Bench for mdu_control: directed ops, an arithmetic reference model checked every cycle,
// and literal expectations for the documented scenarios.
module tb_mdu_control;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam int OP_CYCLES = 33;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdu_control_if #(.DATA_BUS_WIDTH(32), .ALU_FUNCT_BUS_WIDTH(6)) bus();

  mdu_control #(.DATA_BUS_WIDTH(32), .ALU_FUNCT_BUS_WIDTH(6)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: results from plain arithmetic, released after the fixed latency
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_done = 1'b0, m_dbz = 1'b0;
  bit          cmp_en = 1'b0;

  always @(posedge clk) begin : model
    int          left;
    logic [31:0] hi, lo, ph, pl, a, b;
    logic        dn, dz;
    longint      sa, sb, sp, sq, sr;
    logic [63:0] up;
    left = m_left; hi = m_hi; lo = m_lo; ph = p_hi; pl = p_lo;
    dn = 1'b0; dz = 1'b0;
    a = bus.i_op_a; b = bus.i_op_b;
    if (rst) begin
      left = 0; hi = '0; lo = '0;
    end else if (left > 0) begin
      left--;
      if (left == 0) begin
        hi = ph; lo = pl; dn = 1'b1;
      end
    end else if (bus.i_start) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (bus.i_funct)
        FN_MTHI: hi = a;
        FN_MTLO: lo = a;
        FN_MULTU: begin
          up = {32'b0, a} * {32'b0, b};
          {ph, pl} = up; left = OP_CYCLES;
        end
        FN_MULT: begin
          sp = sa * sb;
          {ph, pl} = sp; left = OP_CYCLES;
        end
        FN_DIVU: begin
          if (b == 0) begin dn = 1'b1; dz = 1'b1; end
          else begin pl = a / b; ph = a % b; left = OP_CYCLES; end
        end
        FN_DIV: begin
          if (b == 0) begin dn = 1'b1; dz = 1'b1; end
          else begin
            sq = sa / sb; sr = sa % sb;
            pl = sq[31:0]; ph = sr[31:0]; left = OP_CYCLES;
          end
        end
        default: ;
      endcase
    end
    m_left <= left; m_hi <= hi; m_lo <= lo; p_hi <= ph; p_lo <= pl;
    m_done <= dn; m_dbz <= dz;
    if (rst) cmp_en <= 1'b1;
  end

  // scoreboard compare on every falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", bus.o_busy, (m_left > 0));
      check("done", bus.o_done, m_done);
      check("div_by_zero", bus.o_div_by_zero, m_dbz);
      check("hi", bus.o_hi, m_hi);
      check("lo", bus.o_lo, m_lo);
    end
  end

  // driver tasks (entered and left on a falling edge)
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.i_start = 1'b1; bus.i_funct = f; bus.i_op_a = a; bus.i_op_b = b;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_op_a = 32'hDEADBEEF; bus.i_op_b = 32'h0BADF00D;
  endtask

  task automatic wait_done(input string name, output int busy_cycles);
    bit seen;
    busy_cycles = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.o_done) begin seen = 1'b1; break; end
      if (bus.o_busy) busy_cycles++;
      @(negedge clk);
    end
    check({name, "_done_seen"}, seen, 1'b1);
  endtask

  initial begin : stim
    int bc, dn;
    bus.i_start = 1'b0; bus.i_funct = '0; bus.i_op_a = '0; bus.i_op_b = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", bus.o_busy, 1'b0);
    check("reset_hi", bus.o_hi, 32'h0);
    check("reset_lo", bus.o_lo, 32'h0);
    check("reset_done", bus.o_done, 1'b0);
    rst = 1'b0;

    // MULTU max*max: latency and value
    issue(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu_max", bc);
    check("multu_busy_cycles", bc, 33);
    check("multu_hi", bus.o_hi, 32'hFFFFFFFE);
    check("multu_lo", bus.o_lo, 32'h00000001);
    check("model_pin_hi", m_hi, 32'hFFFFFFFE);

    // MULT -3*5, then DIV -7/2 issued in the done cycle
    issue(FN_MULT, 32'hFFFFFFFD, 32'd5);
    wait_done("mult_neg", bc);
    check("mult_hi", bus.o_hi, 32'hFFFFFFFF);
    check("mult_lo", bus.o_lo, 32'hFFFFFFF1);
    issue(FN_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done("div_neg", bc);
    check("div_lo", bus.o_lo, 32'hFFFFFFFD);
    check("div_hi", bus.o_hi, 32'hFFFFFFFF);
    check("model_pin_lo", m_lo, 32'hFFFFFFFD);

    // divide by zero leaves HI/LO alone
    issue(FN_MTHI, 32'h11, 32'h0);
    issue(FN_MTLO, 32'h22, 32'h0);
    issue(FN_DIVU, 32'd100, 32'd0);
    check("dbz_done", bus.o_done, 1'b1);
    check("dbz_flag", bus.o_div_by_zero, 1'b1);
    check("dbz_busy", bus.o_busy, 1'b0);
    check("dbz_hi", bus.o_hi, 32'h11);
    check("dbz_lo", bus.o_lo, 32'h22);
    @(negedge clk);
    check("dbz_pulse_end", bus.o_done, 1'b0);

    // DIVU 100/7 with ignored start pulses while busy
    issue(FN_DIVU, 32'd100, 32'd7);
    dn = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.o_done) dn++;
      bus.i_start = (c == 5 || c == 20);
      bus.i_funct = FN_MULTU; bus.i_op_a = 32'd3; bus.i_op_b = 32'd3;
      @(negedge clk);
    end
    bus.i_start = 1'b0;
    check("divu_done_count", dn, 1);
    check("divu_lo", bus.o_lo, 32'd14);
    check("divu_hi", bus.o_hi, 32'd2);

    // MTLO, then reset in the middle of a MULT
    issue(FN_MTLO, 32'hCAFEF00D, 32'h0);
    check("mtlo_lo", bus.o_lo, 32'hCAFEF00D);
    check("mtlo_busy", bus.o_busy, 1'b0);
    check("mtlo_done", bus.o_done, 1'b0);
    issue(FN_MULT, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", bus.o_busy, 1'b0);
    check("rst_mid_hi", bus.o_hi, 32'h0);
    check("rst_mid_lo", bus.o_lo, 32'h0);
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.o_done) dn++;
      @(negedge clk);
    end
    check("rst_mid_no_done", dn, 0);

    // unknown funct ignored
    issue(6'h20, 32'd1, 32'd2);
    check("bad_funct_busy", bus.o_busy, 1'b0);
    check("bad_funct_done", bus.o_done, 1'b0);

    // signed overflow divide
    issue(FN_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_ovf", bc);
    check("ovf_lo", bus.o_lo, 32'h80000000);
    check("ovf_hi", bus.o_hi, 32'h0);
    check("ovf_dbz", bus.o_div_by_zero, 1'b0);

    // further model-checked patterns
    issue(FN_MULTU, 32'h12345678, 32'h9ABCDEF0);
    wait_done("multu_mix", bc);
    issue(FN_DIV, 32'd7, 32'hFFFFFFFE);
    wait_done("div_pos_neg", bc);
    check("div7m2_lo", bus.o_lo, 32'hFFFFFFFD);
    check("div7m2_hi", bus.o_hi, 32'd1);
    issue(FN_DIVU, 32'hFFFFFFFF, 32'd1);
    wait_done("divu_one", bc);
    issue(FN_MULT, 32'h80000000, 32'h80000000);
    wait_done("mult_min", bc);
    check("multmin_hi", bus.o_hi, 32'h40000000);
    check("multmin_lo", bus.o_lo, 32'h0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
